leb128_decoder: RTL and testbench
=================================

Name: leb128_decoder

Overview:
- Upstream stage of the cpu's instruction decoder.
- Consumes the byte stream fetched from the ROM and decodes one WebAssembly LEB128 immediate per request. Immediates include i32.const/i64.const operands, local indices and branch depths.
- Delivers the value as a 64-bit word ready to push onto the operand stack.
- Malformed encodings raise an error the cpu maps onto its trap output.

Parameters:
- DATA_W, 64, width of the decoded value output; fixed at 64, matching the cpu result/stack width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a decode; sampled only when not busy
- is_signed  input  1  1 = sLEB128, 0 = uLEB128; latched on start
- is_64  input  1  1 = 64-bit target (max 10 bytes), 0 = 32-bit target (max 5 bytes); latched on start
- byte_in  input  8  next encoded byte from the ROM fetch path
- byte_valid  input  1  byte_in holds a valid byte
- byte_ready  output  1  decoder accepts byte_in this cycle
- value  output  64  decoded value, valid while done=1
- len  output  4  bytes consumed by the finished decode (1..10)
- done  output  1  one-cycle pulse: value/len valid
- error  output  1  one-cycle pulse: malformed encoding
- busy  output  1  decode in progress

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. All outputs are 0: byte_ready, value, len, done, error, busy. Reset mid-decode abandons the partial value with no done or error pulse.
- State IDLE: byte_ready=0, busy=0. start=1 moves to DECODE, latches is_signed/is_64, and clears accumulator, shift and count.
- State DECODE: byte_ready=1, busy=1, start ignored. A byte transfers on byte_valid && byte_ready. Gaps in byte_valid stall with no state change. Each accepted byte does:
  - acc |= byte_in[6:0] << shift
  - shift += 7
  - count += 1
- Termination: an accepted byte with byte_in[7]=0 ends the decode. done=1, value and len are registered in the next cycle, and the FSM moves to state RESULT.
- Sign extension (is_signed=1): if the last byte has bit6=1 and shift<64, the result is acc | (~0 << shift).
- 32-bit target: value[63:32] = is_signed ? {32{value[31]}} : 32'h0.
- State RESULT: lasts one cycle.
  - done=1 and busy=0; value/len hold the result.
  - start in this cycle is accepted and moves directly to DECODE, so back-to-back immediates are possible.
  - Otherwise the FSM returns to IDLE.
  - value/len hold their last result until the next done.
- Error conditions, checked on the byte that triggers them:
  - Overlong: count reaches the max (5 or 10) and that byte has byte_in[7]=1.
  - 32-bit, 5th byte, unsigned: byte_in[6:4] must be 0.
  - 32-bit, 5th byte, signed: byte_in[6:3] must be all 0 or all 1.
  - 64-bit, 10th byte, unsigned: byte_in[6:1] must be 0.
  - 64-bit, 10th byte, signed: byte_in[6:0] must be 7'h00 or 7'h7F.
- On error: error=1 for one cycle in the next cycle, done stays 0, value/len are unchanged, state returns to IDLE. No further bytes are consumed.
- Latency: done or error is asserted exactly 1 cycle after the last byte is accepted. Minimum per-immediate throughput is len+1 cycles.
- done and error are never asserted together.

Decomposition:
- A shared header holds:
  - LEB_MAX_BYTES_32 = 5 and LEB_MAX_BYTES_64 = 10
  - state encodings IDLE/DECODE/RESULT
  - the cpu trap code assigned to a malformed immediate, which the cpu drives when error=1
- No sub-module. The final-byte legality check is a small combinational function inside the block.

Test Plan:
1. Unsigned i32, bytes E5 8E 26, one per cycle -> done 1 cycle after 26; value=0x0000_0000_0009_8765 (624485), len=3.
2. Signed i32, bytes C0 BB 78 -> value=0xFFFF_FFFF_FFFE_1DC0 (-123456), len=3. Then start during RESULT with byte 00 -> second done, value=0, len=1.
3. Signed i64, byte 7F -> value=0xFFFF_FFFF_FFFF_FFFF, len=1. Unsigned i64, byte 7F -> value=0x7F.
4. Unsigned i32, bytes FF FF FF FF 0F -> value=0x0000_0000_FFFF_FFFF, len=5. Bytes FF FF FF FF 1F -> error pulse, no done, value unchanged.
5. Unsigned i32, bytes 80 80 80 80 80 -> error 1 cycle after 5th byte; byte_ready=0 afterwards; busy=0.
6. Signed i32, bytes C0 BB with byte_valid gaps of 3 cycles, then reset before 78 -> all outputs 0 next cycle; a fresh decode of 01 gives value=1, len=1.

Source files
------------

// File: rtl/leb128_decoder_pkg.sv
// Shared constants and FSM encoding for the WebAssembly LEB128 immediate decoder.
package leb128_decoder_pkg;

  localparam int         DATA_W           = 64;
  localparam logic [3:0] LEB_MAX_BYTES_32 = 4'd5;
  localparam logic [3:0] LEB_MAX_BYTES_64 = 4'd10;

  // Trap code the cpu drives on its trap output when the decoder raises error.
  localparam logic [7:0] LEB_TRAP_CODE    = 8'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESULT = 2'd2
  } leb_state_e;

endpackage

// File: rtl/leb128_decoder_if.sv
// Request/byte-stream/result bundle between the instruction decoder and the LEB128 unit.
interface leb128_decoder_if;
  import leb128_decoder_pkg::*;

  logic              start;
  logic              is_signed;
  logic              is_64;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] value;
  logic [3:0]        len;
  logic              done;
  logic              error;
  logic              busy;

  modport master (
    output start, is_signed, is_64, byte_in, byte_valid,
    input  byte_ready, value, len, done, error, busy
  );

  modport slave (
    input  start, is_signed, is_64, byte_in, byte_valid,
    output byte_ready, value, len, done, error, busy
  );

endinterface

// File: rtl/leb128_decoder.sv
// Decodes one uLEB128/sLEB128 immediate per request into a 64-bit operand-stack word.
module leb128_decoder
  import leb128_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  leb128_decoder_if.slave  bus
);

  leb_state_e        state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt, result, value_q;
  logic [6:0]        shift, shift_nxt;
  logic [3:0]        count, count_nxt, len_q;
  logic              sgn, w64, error_q;
  logic              load, accept, bad, last;

  // Legality of the byte that lands on the target's maximum length: it must
  // terminate, and its unused high payload bits must be zero (unsigned) or a
  // clean sign extension (signed).
  function automatic logic final_byte_bad(input logic [7:0] b, input logic [3:0] cnt,
                                          input logic s, input logic w);
    logic at_max;
    at_max = w ? (cnt == LEB_MAX_BYTES_64) : (cnt == LEB_MAX_BYTES_32);
    if (!at_max)  return 1'b0;
    if (b[7])     return 1'b1;
    if (w)        return s ? !(b[6:0] == 7'h00 || b[6:0] == 7'h7F) : (b[6:1] != 6'd0);
    return s ? !(b[6:3] == 4'h0 || b[6:3] == 4'hF) : (b[6:4] != 3'd0);
  endfunction

  assign load      = bus.start && (state == IDLE || state == RESULT);
  assign accept    = (state == DECODE) && bus.byte_valid;
  assign acc_nxt   = acc | (DATA_W'(bus.byte_in[6:0]) << shift);
  assign shift_nxt = shift + 7'd7;
  assign count_nxt = count + 4'd1;
  assign bad       = final_byte_bad(bus.byte_in, count_nxt, sgn, w64);
  assign last      = !bus.byte_in[7];

  always_comb begin
    result = acc_nxt;
    if (sgn && bus.byte_in[6] && shift_nxt < 7'd64)
      result = result | ({DATA_W{1'b1}} << shift_nxt);
    if (!w64)
      result[63:32] = sgn ? {32{result[31]}} : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DECODE;
      DECODE: begin
        if (accept) begin
          if (bad)       state_nxt = IDLE;
          else if (last) state_nxt = RESULT;
        end
      end
      RESULT:  state_nxt = bus.start ? DECODE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      shift   <= '0;
      count   <= '0;
      sgn     <= 1'b0;
      w64     <= 1'b0;
      value_q <= '0;
      len_q   <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= accept && bad;
      if (load) begin
        acc   <= '0;
        shift <= '0;
        count <= '0;
        sgn   <= bus.is_signed;
        w64   <= bus.is_64;
      end else if (accept) begin
        acc   <= acc_nxt;
        shift <= shift_nxt;
        count <= count_nxt;
      end
      // A rejected byte leaves the previous result visible.
      if (accept && !bad && last) begin
        value_q <= result;
        len_q   <= count_nxt;
      end
    end
  end

  assign bus.byte_ready = (state == DECODE);
  assign bus.busy       = (state == DECODE);
  assign bus.done       = (state == RESULT);
  assign bus.error      = error_q;
  assign bus.value      = value_q;
  assign bus.len        = len_q;

  a_done_error_excl: assert property (@(posedge clk) disable iff (reset) !(bus.done && bus.error));
  a_error_idle:      assert property (@(posedge clk) disable iff (reset) bus.error |-> !bus.busy);

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed vector bench for leb128_decoder: table of immediates plus hand-written corner sequences.
module tb_leb128_decoder;
  import leb128_decoder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leb128_decoder_if bus ();

  leb128_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sgn;
    logic        w64;
    int          n;
    logic [79:0] bytes;   // first byte in [7:0]
    logic        err;
    logic [63:0] val;
    logic [3:0]  len;
  } vec_t;

  int total  = 0;
  int passed = 0;
  logic [63:0] last_val;
  logic [3:0]  last_len;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic s, input logic w, input int n, input logic [79:0] b,
                              input logic e, input logic [63:0] v, input logic [3:0] l);
    vec_t t;
    t.sgn = s; t.w64 = w; t.n = n; t.bytes = b; t.err = e; t.val = v; t.len = l;
    return t;
  endfunction

  // Starts from IDLE at a negedge; leaves the DUT idle at a negedge.
  task automatic run_vec(input string name, input vec_t v);
    logic [7:0] b;
    bus.start = 1'b1; bus.is_signed = v.sgn; bus.is_64 = v.w64; bus.byte_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      chk({name, " byte_ready"}, 64'(bus.byte_ready), 64'd1);
      b = v.bytes[8*i +: 8];
      bus.byte_in = b; bus.byte_valid = 1'b1;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    chk({name, " done"},  64'(bus.done),  64'(!v.err));
    chk({name, " error"}, 64'(bus.error), 64'(v.err));
    chk({name, " busy"},  64'(bus.busy),  64'd0);
    if (v.err) begin
      chk({name, " ready after err"}, 64'(bus.byte_ready), 64'd0);
      chk({name, " value kept"}, bus.value, last_val);
      chk({name, " len kept"},   64'(bus.len), 64'(last_len));
    end else begin
      chk({name, " value"}, bus.value, v.val);
      chk({name, " len"},   64'(bus.len), 64'(v.len));
      last_val = v.val; last_len = v.len;
    end
    @(negedge clk);
    chk({name, " pulse end"}, 64'({bus.done, bus.error, bus.byte_ready}), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 3,  80'h268EE5,                0, 64'h0000_0000_0009_8765, 4'd3);
    vecs[1]  = mk(1, 0, 3,  80'h78BBC0,                0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3);
    vecs[2]  = mk(1, 1, 1,  80'h7F,                    0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
    vecs[3]  = mk(0, 1, 1,  80'h7F,                    0, 64'h0000_0000_0000_007F, 4'd1);
    vecs[4]  = mk(0, 0, 5,  80'h0FFFFFFFFF,            0, 64'h0000_0000_FFFF_FFFF, 4'd5);
    vecs[5]  = mk(0, 0, 5,  80'h1FFFFFFFFF,            1, 64'h0, 4'd0);
    vecs[6]  = mk(0, 0, 5,  80'h8080808080,            1, 64'h0, 4'd0);
    vecs[7]  = mk(1, 0, 5,  80'h7FFFFFFFFF,            0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5);
    vecs[8]  = mk(1, 0, 5,  80'h7880808080,            0, 64'hFFFF_FFFF_8000_0000, 4'd5);
    vecs[9]  = mk(1, 0, 5,  80'h0880808080,            1, 64'h0, 4'd0);
    vecs[10] = mk(0, 1, 10, 80'h01FFFFFFFFFFFFFFFFFF,  0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10);
    vecs[11] = mk(0, 1, 10, 80'h02FFFFFFFFFFFFFFFFFF,  1, 64'h0, 4'd0);
    vecs[12] = mk(1, 1, 10, 80'h7F808080808080808080,  0, 64'h8000_0000_0000_0000, 4'd10);
    vecs[13] = mk(1, 1, 10, 80'h01808080808080808080,  1, 64'h0, 4'd0);
    vecs[14] = mk(1, 1, 2,  80'h7F80,                  0, 64'hFFFF_FFFF_FFFF_FF80, 4'd2);
    vecs[15] = mk(0, 0, 5,  80'h8F80808080,            1, 64'h0, 4'd0);

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.is_64 = 1'b0;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", 64'({bus.byte_ready, bus.done, bus.error, bus.busy, bus.len}), 64'd0);
    chk("reset value", bus.value, 64'd0);
    reset = 1'b0;
    last_val = 64'd0; last_len = 4'd0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back: start during RESULT goes straight to DECODE.
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.is_64 = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'hC0; @(negedge clk);
    bus.byte_in = 8'hBB; @(negedge clk);
    bus.byte_in = 8'h78; @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("b2b first done", 64'(bus.done), 64'd1);
    chk("b2b first value", bus.value, 64'hFFFF_FFFF_FFFE_1DC0);
    bus.start = 1'b1; bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b re-entered decode", 64'({bus.busy, bus.byte_ready, bus.done}), 64'b110);
    bus.byte_in = 8'h00; bus.byte_valid = 1'b1;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("b2b second done", 64'(bus.done), 64'd1);
    chk("b2b second value", bus.value, 64'd0);
    chk("b2b second len", 64'(bus.len), 64'd1);
    @(negedge clk);

    // start during DECODE is ignored, and byte_valid gaps stall.
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.is_64 = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_in = 8'hE5; bus.byte_valid = 1'b1; @(negedge clk);
    bus.byte_valid = 1'b0; bus.start = 1'b1; bus.is_signed = 1'b1; @(negedge clk);
    bus.start = 1'b0;
    chk("stall busy", 64'({bus.busy, bus.done, bus.error}), 64'b100);
    bus.byte_in = 8'h8E; bus.byte_valid = 1'b1; @(negedge clk);
    bus.byte_in = 8'h26; @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("stall done", 64'(bus.done), 64'd1);
    chk("stall value", bus.value, 64'h0000_0000_0009_8765);
    chk("stall len", 64'(bus.len), 64'd3);
    @(negedge clk);

    // Reset mid-decode after gapped bytes abandons the partial value.
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.is_64 = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.byte_in = 8'hC0; bus.byte_valid = 1'b1; @(negedge clk);
    bus.byte_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("gap%0d", g), 64'({bus.busy, bus.byte_ready, bus.done, bus.error}), 64'b1100);
      @(negedge clk);
    end
    bus.byte_in = 8'hBB; bus.byte_valid = 1'b1; @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset flags", 64'({bus.byte_ready, bus.done, bus.error, bus.busy, bus.len}), 64'd0);
    chk("midreset value", bus.value, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset idle", 64'({bus.byte_ready, bus.done, bus.error, bus.busy}), 64'd0);
    last_val = 64'd0; last_len = 4'd0;
    run_vec("fresh01", mk(0, 0, 1, 80'h01, 0, 64'd1, 4'd1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
